data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Sits between two masters and the 1 kB single-port data SRAM macro (32x256, port 0 only):
  - the ibex core data port (req/gnt/rvalid protocol);
  - a fabric-side master routed through the bottom user-IO bus.
- Replaces the constant-1 data rvalid with a true one-cycle-latency response path.
- Adds 2-way round-robin arbitration and out-of-range error responses.
- Drives the macro's active-low chip-select, write-enable and mask pins directly.

Parameters:
- SRAM_AW, 8, SRAM word-address width (256 words).
- BYTE_AW, 10, byte-address bits decoded as "in range" (SRAM_AW+2).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, cpu wins.

Ports:
- clk  in  1  system clock, shared with the core and the macro
- resetn  in  1  asynchronous active-low reset
- cpu_req_i  in  1  core data request
- cpu_gnt_o  out  1  core grant (combinational, same cycle as req)
- cpu_rvalid_o  out  1  core response valid
- cpu_we_i  in  1  1 = write
- cpu_be_i  in  4  byte enables
- cpu_addr_i  in  32  byte address
- cpu_wdata_i  in  32  write data
- cpu_rdata_o  out  32  read data
- cpu_err_o  out  1  error flag, qualified by cpu_rvalid_o
- fab_req_i, fab_gnt_o, fab_rvalid_o, fab_we_i, fab_be_i[4], fab_addr_i[32], fab_wdata_i[32], fab_rdata_o[32], fab_err_o: identical semantics for the fabric master
- sram_csb0_o  out  1  macro chip select, active low
- sram_web0_o  out  1  macro write enable, active low
- sram_wmask0_o  out  4  macro write mask
- sram_addr0_o  out  SRAM_AW  macro word address
- sram_din0_o  out  32  macro write data
- sram_dout0_i  in  32  macro read data, valid the cycle after access

Behaviour:
- Reset: while resetn=0, all outputs are forced as follows:
  - gnt_o, rvalid_o and err_o are 0; rdata_o is 0;
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0;
  - last_winner is set to fab, so cpu wins the first tie.
- Grant:
  - At most one grant per cycle.
  - A single requester is granted in the same cycle.
  - If both request and RR_EN=1, the master that did not win last is granted; if RR_EN=0, cpu is granted.
  - last_winner updates only on a grant.
  - req with no gnt: the master holds its request stable, per protocol.
- Range check: an access is in range when addr[31:BYTE_AW]==0.
- Access on grant, in range:
  - csb0=0, web0=~we, wmask0=we?be:4'h0, addr0=addr[BYTE_AW-1:2], din0=wdata, all combinational in the grant cycle.
  - The macro samples them at the next posedge.
- Access on grant, out of range: the SRAM is not selected (csb0 stays 1); a pending error is recorded.
- Response:
  - rvalid is asserted exactly 1 cycle after the grant, for one cycle, to the granted master only.
  - Applies to reads and writes alike; the response is never dropped or merged.
  - Back-to-back grants give back-to-back rvalids, at one access per cycle.
- Read data:
  - On rvalid for an in-range read, rdata_o = sram_dout0_i and the value is captured into a per-port hold register.
  - On rvalid for an error, rdata_o = 0 and err_o = 1.
  - Between rvalids, rdata_o presents the hold register.
  - A write response leaves the hold register unchanged.
- Pipeline state: resp_valid, resp_port, resp_err and resp_we are registered at the grant cycle.
- Simultaneous events:
  - A grant in the same cycle as an rvalid to the same or the other master is legal.
  - The new grant's response follows one cycle later.
- Byte enables on a read are ignored; the full word is returned.
- A write with be=0 still generates csb0=0 and an rvalid.
- Reset asserted mid-transaction: a pending response is discarded, with no rvalid after reset release.
- Idle: csb0=1 whenever no grant occurs in that cycle.

Decomposition:
- Package data_mem_pkg holds:
  - WORD_W=32 and SRAM_AW=8;
  - BYTE_AW;
  - the port-id enum {PORT_CPU=0, PORT_FAB=1};
  - the response-state struct {valid, port, err, we}.
- Sub-module rr_arb2 (2-input round-robin arbiter with last-winner register and RR_EN bypass) is instantiated once.
- Everything else lives in the top module.

Test Plan:
- Reset check: hold resetn=0 with cpu_req_i=1 -> gnt=0, csb0=1, web0=1, rvalid=0. Release -> gnt=1 in the same cycle.
- Core write then read: cpu write addr 0x0000_0010, data 0xDEADBEEF, be=0xF -> gnt same cycle; csb0=0, web0=0, addr0=0x04, wmask0=0xF; rvalid next cycle with err=0. Read of the same address -> rdata=0xDEADBEEF one cycle after gnt.
- Contention: both masters request continuously for 4 cycles, RR_EN=1 -> grants cpu, fab, cpu, fab; each rvalid goes only to its owner one cycle later. With RR_EN=0 -> cpu gets all 4.
- Out of range: fab read addr 0x0000_0400 -> gnt=1, csb0 stays 1, next cycle fab_rvalid=1, fab_err=1, fab_rdata=0. The cpu hold register is unchanged.
- Byte write: cpu write be=0x2, data 0x0000AB00 to a word holding 0x11223344 -> wmask0=0x2; a subsequent read returns 0x1122AB44.
- Reset mid-operation: assert resetn=0 in the cycle after a cpu read grant -> no cpu_rvalid during or after reset; rdata=0 after release.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared constants and types for the data SRAM arbiter
package data_mem_pkg;
  localparam int WORD_W  = 32;
  localparam int SRAM_AW = 8;
  localparam int BYTE_AW = SRAM_AW + 2;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_FAB = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
    logic  we;
  } resp_t;
endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rtl/data_mem_arbiter_rr_arb2.sv - two-input round-robin arbiter with fixed-priority bypass
module rr_arb2
  import data_mem_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  port_e r_last;
  logic  w_pick_fab;

  // On a tie the master that lost last time wins; with RR_EN=0 the cpu always wins.
  always_comb begin
    w_pick_fab = 1'b0;
    o_gnt      = 2'b00;
    if (i_req == 2'b11) begin
      w_pick_fab = (RR_EN != 0) && (r_last == PORT_CPU);
    end else begin
      w_pick_fab = i_req[1];
    end
    if (i_req != 2'b00) begin
      o_gnt = w_pick_fab ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= PORT_FAB;
    end else if (|o_gnt) begin
      r_last <= w_pick_fab ? PORT_FAB : PORT_CPU;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-master arbiter for the single-port data SRAM macro
module data_mem_arbiter #(
  parameter int SRAM_AW = data_mem_pkg::SRAM_AW,
  parameter int BYTE_AW = data_mem_pkg::BYTE_AW,
  parameter int RR_EN   = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cpu_req_i,
  output logic               cpu_gnt_o,
  output logic               cpu_rvalid_o,
  input  logic               cpu_we_i,
  input  logic [3:0]         cpu_be_i,
  input  logic [31:0]        cpu_addr_i,
  input  logic [31:0]        cpu_wdata_i,
  output logic [31:0]        cpu_rdata_o,
  output logic               cpu_err_o,
  input  logic               fab_req_i,
  output logic               fab_gnt_o,
  output logic               fab_rvalid_o,
  input  logic               fab_we_i,
  input  logic [3:0]         fab_be_i,
  input  logic [31:0]        fab_addr_i,
  input  logic [31:0]        fab_wdata_i,
  output logic [31:0]        fab_rdata_o,
  output logic               fab_err_o,
  output logic               sram_csb0_o,
  output logic               sram_web0_o,
  output logic [3:0]         sram_wmask0_o,
  output logic [SRAM_AW-1:0] sram_addr0_o,
  output logic [31:0]        sram_din0_o,
  input  logic [31:0]        sram_dout0_i
);
  import data_mem_pkg::*;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel_fab;
  logic              w_we;
  logic [3:0]        w_be;
  logic [31:0]       w_addr;
  logic [WORD_W-1:0] w_wdata;
  logic              w_in_range;
  logic              w_access;
  logic              w_unused_addr;

  // Requests are masked during reset so no grant or SRAM select can leak out.
  assign w_req = {fab_req_i, cpu_req_i} & {2{resetn}};

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .i_req  (w_req),
    .o_gnt  (w_gnt)
  );

  assign cpu_gnt_o = w_gnt[0];
  assign fab_gnt_o = w_gnt[1];
  assign w_any     = |w_gnt;
  assign w_sel_fab = w_gnt[1];

  assign w_we          = w_sel_fab ? fab_we_i    : cpu_we_i;
  assign w_be          = w_sel_fab ? fab_be_i    : cpu_be_i;
  assign w_addr        = w_sel_fab ? fab_addr_i  : cpu_addr_i;
  assign w_wdata       = w_sel_fab ? fab_wdata_i : cpu_wdata_i;
  assign w_unused_addr = ^{cpu_addr_i[1:0], fab_addr_i[1:0]};

  assign w_in_range = (w_addr[31:BYTE_AW] == '0);
  assign w_access   = w_any & w_in_range;

  assign sram_csb0_o   = ~w_access;
  assign sram_web0_o   = ~(w_access & w_we);
  assign sram_wmask0_o = (w_access & w_we) ? w_be : 4'h0;
  assign sram_addr0_o  = w_access ? w_addr[BYTE_AW-1:2] : '0;
  assign sram_din0_o   = w_access ? w_wdata : '0;

  resp_t       r_resp;
  logic [31:0] r_cpu_hold;
  logic [31:0] r_fab_hold;
  logic        w_cpu_rv;
  logic        w_fab_rv;
  logic        w_rd_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp <= '0;
    end else begin
      r_resp.valid <= w_any;
      r_resp.port  <= w_sel_fab ? PORT_FAB : PORT_CPU;
      r_resp.err   <= ~w_in_range;
      r_resp.we    <= w_we;
    end
  end

  assign w_cpu_rv = r_resp.valid & (r_resp.port == PORT_CPU);
  assign w_fab_rv = r_resp.valid & (r_resp.port == PORT_FAB);
  assign w_rd_ok  = ~r_resp.err & ~r_resp.we;

  // Only good read responses refresh a port's hold register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cpu_hold <= '0;
      r_fab_hold <= '0;
    end else begin
      if (w_cpu_rv & w_rd_ok) r_cpu_hold <= sram_dout0_i;
      if (w_fab_rv & w_rd_ok) r_fab_hold <= sram_dout0_i;
    end
  end

  assign cpu_rvalid_o = w_cpu_rv;
  assign fab_rvalid_o = w_fab_rv;
  assign cpu_err_o    = w_cpu_rv & r_resp.err;
  assign fab_err_o    = w_fab_rv & r_resp.err;

  assign cpu_rdata_o = (w_cpu_rv & r_resp.err) ? 32'h0 :
                       (w_cpu_rv & w_rd_ok)    ? sram_dout0_i : r_cpu_hold;
  assign fab_rdata_o = (w_fab_rv & r_resp.err) ? 32'h0 :
                       (w_fab_rv & w_rd_ok)    ? sram_dout0_i : r_fab_hold;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with SRAM models
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        cpu_req, cpu_we, fab_req, fab_we;
  logic [3:0]  cpu_be, fab_be;
  logic [31:0] cpu_addr, cpu_wdata, fab_addr, fab_wdata;

  logic        cpu_gnt, cpu_rvalid, cpu_err, fab_gnt, fab_rvalid, fab_err;
  logic [31:0] cpu_rdata, fab_rdata, din, dout;
  logic        csb, web;
  logic [3:0]  wmask;
  logic [7:0]  addr0;

  logic        fp_cpu_gnt, fp_cpu_rvalid, fp_cpu_err, fp_fab_gnt, fp_fab_rvalid, fp_fab_err;
  logic [31:0] fp_cpu_rdata, fp_fab_rdata, fp_din, fp_dout;
  logic        fp_csb, fp_web;
  logic [3:0]  fp_wmask;
  logic [7:0]  fp_addr0;

  data_mem_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req_i(cpu_req), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_we_i(cpu_we),
    .cpu_be_i(cpu_be), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .cpu_err_o(cpu_err),
    .fab_req_i(fab_req), .fab_gnt_o(fab_gnt), .fab_rvalid_o(fab_rvalid), .fab_we_i(fab_we),
    .fab_be_i(fab_be), .fab_addr_i(fab_addr), .fab_wdata_i(fab_wdata), .fab_rdata_o(fab_rdata),
    .fab_err_o(fab_err),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask), .sram_addr0_o(addr0),
    .sram_din0_o(din), .sram_dout0_i(dout)
  );

  data_mem_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .resetn(resetn),
    .cpu_req_i(cpu_req), .cpu_gnt_o(fp_cpu_gnt), .cpu_rvalid_o(fp_cpu_rvalid), .cpu_we_i(cpu_we),
    .cpu_be_i(cpu_be), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(fp_cpu_rdata),
    .cpu_err_o(fp_cpu_err),
    .fab_req_i(fab_req), .fab_gnt_o(fp_fab_gnt), .fab_rvalid_o(fp_fab_rvalid), .fab_we_i(fab_we),
    .fab_be_i(fab_be), .fab_addr_i(fab_addr), .fab_wdata_i(fab_wdata), .fab_rdata_o(fp_fab_rdata),
    .fab_err_o(fp_fab_err),
    .sram_csb0_o(fp_csb), .sram_web0_o(fp_web), .sram_wmask0_o(fp_wmask), .sram_addr0_o(fp_addr0),
    .sram_din0_o(fp_din), .sram_dout0_i(fp_dout)
  );

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++) if (wmask[b]) mem0[addr0][8*b +: 8] <= din[8*b +: 8];
      end else begin
        dout <= mem0[addr0];
      end
    end
  end

  always @(posedge clk) begin
    if (!fp_csb) begin
      if (!fp_web) begin
        for (int b = 0; b < 4; b++) if (fp_wmask[b]) mem1[fp_addr0][8*b +: 8] <= fp_din[8*b +: 8];
      end else begin
        fp_dout <= mem1[fp_addr0];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic set_fab(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    fab_req = req; fab_we = we; fab_be = be; fab_addr = a; fab_wdata = wd;
  endtask

  // One cycle: check grants of both arbiters and the macro pins, queue the expected response.
  task automatic tick(input bit ec, input bit ef, input bit fc, input bit ff,
                      input bit chk_rd, input logic [31:0] erd, input bit push);
    bit          we, inr;
    logic [3:0]  be;
    logic [31:0] a, wd;
    exp_t        e;
    #2;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(ec));
    chk("fab_gnt", 32'(fab_gnt), 32'(ef));
    chk("fp_cpu_gnt", 32'(fp_cpu_gnt), 32'(fc));
    chk("fp_fab_gnt", 32'(fp_fab_gnt), 32'(ff));
    if (ec || ef) begin
      we  = ef ? fab_we : cpu_we;
      be  = ef ? fab_be : cpu_be;
      a   = ef ? fab_addr : cpu_addr;
      wd  = ef ? fab_wdata : cpu_wdata;
      inr = (a[31:10] == 22'h0);
      chk("csb0", 32'(csb), 32'(!inr));
      if (inr) begin
        chk("web0", 32'(web), 32'(!we));
        chk("wmask0", 32'(wmask), we ? 32'(be) : 32'h0);
        chk("addr0", 32'(addr0), 32'(a[9:2]));
        chk("din0", din, wd);
      end
      if (push) begin
        e.port = ef; e.err = !inr; e.chk_rd = chk_rd; e.rd = erd; e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end else begin
      chk("csb0_idle", 32'(csb), 32'h1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      begin : monitor
        exp_t        me;
        bit          p;
        logic [31:0] rd;
        logic        er;
        forever begin
          @(negedge clk);
          if (cpu_rvalid || fab_rvalid) begin
            if (cpu_rvalid) chk("rvalid_both", 32'(fab_rvalid), 32'h0);
            if (sb.size() == 0) begin
              n_chk++; n_err++;
              $display("FAIL rvalid_unexpected: got cpu=%0b fab=%0b expected none (cycle %0d)",
                       cpu_rvalid, fab_rvalid, cyc);
            end else begin
              me = sb.pop_front();
              p  = fab_rvalid;
              rd = p ? fab_rdata : cpu_rdata;
              er = p ? fab_err : cpu_err;
              chk("rv_port", 32'(p), 32'(me.port));
              chk("rv_cycle", 32'(cyc), 32'(me.cyc));
              chk("rv_err", 32'(er), 32'(me.err));
              if (me.err) chk("rv_rdata_err", rd, 32'h0);
              else if (me.chk_rd) chk("rv_rdata", rd, me.rd);
            end
          end
        end
      end
    join_none

    // Reset holds everything quiet even with a pending request.
    resetn = 1'b0;
    set_cpu(1, 0, 4'hF, 32'h0, 32'h0);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
    chk("rst_fab_gnt", 32'(fab_gnt), 32'h0);
    chk("rst_csb0", 32'(csb), 32'h1);
    chk("rst_web0", 32'(web), 32'h1);
    chk("rst_wmask0", 32'(wmask), 32'h0);
    chk("rst_addr0", 32'(addr0), 32'h0);
    chk("rst_din0", din, 32'h0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("rst_fab_rvalid", 32'(fab_rvalid), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_cpu_err", 32'(cpu_err), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(1, 0, 1, 0, 0, 32'h0, 1);

    // Core write then read back.
    set_cpu(1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    tick(1, 0, 1, 0, 0, 32'h0, 1);
    set_cpu(1, 0, 4'hF, 32'h0000_0010, 32'h0);
    tick(1, 0, 1, 0, 1, 32'hDEAD_BEEF, 1);
    set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
    tick(0, 0, 0, 0, 0, 32'h0, 1);
    chk("cpu_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Out-of-range fabric read.
    set_fab(1, 0, 4'hF, 32'h0000_0400, 32'h0);
    tick(0, 1, 0, 1, 0, 32'h0, 1);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0);
    tick(0, 0, 0, 0, 0, 32'h0, 1);
    chk("cpu_hold_after_err", cpu_rdata, 32'hDEAD_BEEF);
    chk("fab_hold_after_err", fab_rdata, 32'h0);

    // Contention: round-robin alternates, fixed priority keeps the cpu.
    set_cpu(1, 1, 4'hF, 32'h0000_0020, 32'hA5A5_0001);
    set_fab(1, 1, 4'hF, 32'h0000_0024, 32'h5A5A_0002);
    tick(1, 0, 1, 0, 0, 32'h0, 1);
    tick(0, 1, 1, 0, 0, 32'h0, 1);
    tick(1, 0, 1, 0, 0, 32'h0, 1);
    tick(0, 1, 1, 0, 0, 32'h0, 1);
    chk("cpu_hold_after_writes", cpu_rdata, 32'hDEAD_BEEF);

    set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
    set_fab(1, 0, 4'hF, 32'h0000_0024, 32'h0);
    tick(0, 1, 0, 1, 1, 32'h5A5A_0002, 1);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0);
    set_cpu(1, 0, 4'hF, 32'h0000_0020, 32'h0);
    tick(1, 0, 1, 0, 1, 32'hA5A5_0001, 1);

    // Byte-lane write, empty-mask write, read with be=0.
    set_cpu(1, 1, 4'hF, 32'h0000_0030, 32'h1122_3344);
    tick(1, 0, 1, 0, 0, 32'h0, 1);
    set_cpu(1, 1, 4'h2, 32'h0000_0030, 32'h0000_AB00);
    tick(1, 0, 1, 0, 0, 32'h0, 1);
    set_cpu(1, 1, 4'h0, 32'h0000_0030, 32'hFFFF_FFFF);
    tick(1, 0, 1, 0, 0, 32'h0, 1);
    set_cpu(1, 0, 4'h0, 32'h0000_0030, 32'h0);
    tick(1, 0, 1, 0, 1, 32'h1122_AB44, 1);

    // Reset lands on the response cycle of a read; the response must vanish.
    set_cpu(1, 0, 4'hF, 32'h0000_0010, 32'h0);
    tick(1, 0, 1, 0, 0, 32'h0, 0);
    resetn = 1'b0;
    set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
    #2;
    chk("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("midrst_cpu_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(0, 0, 0, 0, 0, 32'h0, 1);
    tick(0, 0, 0, 0, 0, 32'h0, 1);
    chk("post_rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("post_rst_fab_rdata", fab_rdata, 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
